// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word reads to a
// synchronous instruction memory (one-cycle read latency), buffers returned
// words in a 2-entry FIFO and hands them to the decoder over valid/ready.
// Change-of-flow requests (branch, jump, jr) from downstream retarget the PC
// and flush every fetch that has not yet been accepted by the decoder.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_base,
    input  logic [15:0] redirect_imm,
    input  logic [25:0] redirect_target,
    input  logic [31:0] redirect_reg,
    output logic        addr_err
);

    localparam logic [1:0] RT_BRANCH = 2'b00;
    localparam logic [1:0] RT_JUMP   = 2'b01;

    // Program counter and the address of the read currently in flight.
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;

    // Two-entry FIFO: parallel data/PC storage with 1-bit pointers.
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_data_d [2];
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_pc_d   [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    // Sticky misaligned-jr flag.
    logic        addr_err_q, addr_err_d;

    // Handshake and flow-control terms.
    logic        fifo_nonempty;
    logic        pop;
    logic        push;
    logic [2:0]  occupancy;
    logic [31:0] seq_base;
    logic [31:0] redirect_pc;
    logic        jr_misaligned;

    // Sign-extended word offset converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        logic signed [31:0] ext;
        ext = signed'({{16{imm[15]}}, imm});
        return 32'(ext <<< 2);
    endfunction

    // Redirect target selection; type 2'b11 behaves exactly like jr.
    always_comb begin
        seq_base      = redirect_base + 32'd4;
        jr_misaligned = (redirect_reg[1:0] != 2'b00);
        case (redirect_type)
            RT_BRANCH: redirect_pc = seq_base + branch_offset(redirect_imm);
            RT_JUMP:   redirect_pc = {seq_base[31:28], redirect_target, 2'b00};
            default:   redirect_pc = {redirect_reg[31:2], 2'b00};
        endcase
    end

    // Request rule: keep at most two words buffered or outstanding, counting
    // a same-cycle pop as already freeing its slot. Reset and redirect block
    // new requests so nothing is fetched from a stale PC.
    always_comb begin
        fifo_nonempty = (count_q != 2'd0);
        instr_valid   = !reset && fifo_nonempty;
        pop           = instr_valid && instr_ready;
        occupancy     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        imem_req      = !reset && !redirect && (occupancy < 3'd2);
        push          = inflight_q && !redirect;
        imem_addr     = pc_q;
    end

    // Decoder-facing outputs read zero while reset is held.
    always_comb begin
        instruction = reset ? 32'd0 : fifo_data_q[rd_ptr_q];
        instr_pc    = reset ? 32'd0 : fifo_pc_q[rd_ptr_q];
        addr_err    = !reset && addr_err_q;
    end

    // PC sequencing, in-flight tracking and redirect handling.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        addr_err_d = addr_err_q;
        if (redirect) begin
            pc_d = redirect_pc;
            if (redirect_type != RT_BRANCH && redirect_type != RT_JUMP) begin
                addr_err_d = addr_err_q | jr_misaligned;
            end
        end else if (imem_req) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
    end

    // FIFO bookkeeping; a redirect empties it after honouring any pop.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]   = req_pc_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            inflight_q     <= 1'b0;
            addr_err_q     <= 1'b0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            fifo_data_q[0] <= 32'd0;
            fifo_data_q[1] <= 32'd0;
            fifo_pc_q[0]   <= 32'd0;
            fifo_pc_q[1]   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            addr_err_q  <= addr_err_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level queue model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [1:0]  redirect_type;
    logic [31:0] redirect_base;
    logic [15:0] redirect_imm;
    logic [25:0] redirect_target;
    logic [31:0] redirect_reg;
    logic        addr_err;

    int ntests = 0;
    int nfail  = 0;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_type(redirect_type), .redirect_base(redirect_base),
        .redirect_imm(redirect_imm), .redirect_target(redirect_target),
        .redirect_reg(redirect_reg), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word at byte address a holds a>>2.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    // Reference model: fetch PC, one outstanding request, queue of fetched PCs.
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_err;
    logic [31:0] m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_infl = 0; m_infl_pc = 0; m_err = 0; m_q.delete();
    endtask

    // One clock: check outputs at the falling edge, advance model at rising edge.
    task automatic tick();
        bit e_valid, e_pop, e_req;
        logic signed [31:0] off;
        logic [31:0] nb;
        @(negedge clk);
        if (reset) begin
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_instr", instruction, 32'd0);
            chk("rst_ipc", instr_pc, 32'd0);
            chk("rst_err", {31'd0, addr_err}, 32'd0);
            e_pop = 0; e_req = 0;
        end else begin
            e_valid = (m_q.size() > 0);
            e_pop   = e_valid && instr_ready;
            e_req   = !redirect && ((m_q.size() + int'(m_infl) - int'(e_pop)) < 2);
            chk("valid", {31'd0, instr_valid}, {31'd0, e_valid});
            chk("req", {31'd0, imem_req}, {31'd0, e_req});
            chk("addr", imem_addr, m_pc);
            chk("err", {31'd0, addr_err}, {31'd0, m_err});
            chk("no_overflow", 32'(m_q.size() + int'(m_infl) <= 2), 32'd1);
            if (e_valid) begin
                chk("ipc", instr_pc, m_q[0]);
                chk("instr", instruction, m_q[0] >> 2);
            end
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (redirect) begin
                m_q.delete();
                m_infl = 0;
                nb = redirect_base + 32'd4;
                case (redirect_type)
                    2'b00: begin
                        off  = signed'({{16{redirect_imm[15]}}, redirect_imm});
                        m_pc = nb + 32'(off * 4);
                    end
                    2'b01: m_pc = {nb[31:28], redirect_target, 2'b00};
                    default: begin
                        m_pc  = redirect_reg & 32'hFFFF_FFFC;
                        m_err = m_err || (redirect_reg[1:0] != 2'b00);
                    end
                endcase
            end else begin
                if (m_infl) m_q.push_back(m_infl_pc);
                if (e_req) begin
                    m_infl = 1; m_infl_pc = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    m_infl = 0;
                end
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_redirect(input logic [1:0] t, input logic [31:0] base,
                               input logic [15:0] imm, input logic [25:0] tgt,
                               input logic [31:0] r);
        redirect = 1; redirect_type = t; redirect_base = base;
        redirect_imm = imm; redirect_target = tgt; redirect_reg = r;
        tick();
        redirect = 0;
    endtask

    initial begin
        reset = 1; instr_ready = 1; redirect = 0; redirect_type = 0;
        redirect_base = 0; redirect_imm = 0; redirect_target = 0; redirect_reg = 0;
        @(posedge clk); #1;
        model_reset();
        ticks(2);

        // Streaming from reset: 0,4,8,... once per cycle.
        reset = 0;
        ticks(2);
        chk("first_ipc", instr_pc, 32'h0);
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("second_ipc", instr_pc, 32'h4);
        ticks(6);

        // Backpressure from cycle 2 after a fresh reset.
        reset = 1; tick(); reset = 0;
        instr_ready = 0;
        ticks(6);
        chk("bp_hold_ipc", instr_pc, 32'h0);
        chk("bp_req_low", {31'd0, imem_req}, 32'd0);
        instr_ready = 1;
        ticks(5);

        // Branch backwards: 0x10 + 4 - 8 = 0x0C.
        do_redirect(2'b00, 32'h10, 16'hFFFE, 26'h0, 32'h0);
        chk("br_addr", imem_addr, 32'h0C);
        ticks(2);
        chk("br_ipc", instr_pc, 32'h0C);
        chk("br_valid", {31'd0, instr_valid}, 32'd1);
        ticks(3);

        // Jump keeps upper nibble of base+4.
        do_redirect(2'b01, 32'h4000_0000, 16'h0, 26'h000100, 32'h0);
        chk("jmp_addr", imem_addr, 32'h4000_0400);
        ticks(4);

        // Misaligned jr sets the sticky error; aligned jr keeps it.
        do_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0023);
        chk("jr_addr", imem_addr, 32'h20);
        chk("jr_err", {31'd0, addr_err}, 32'd1);
        ticks(3);
        do_redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_0044);
        chk("jr2_addr", imem_addr, 32'h44);
        chk("jr2_err", {31'd0, addr_err}, 32'd1);
        ticks(3);

        // Back-to-back redirects: last one wins.
        do_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_1000);
        do_redirect(2'b00, 32'h200, 16'h0003, 26'h0, 32'h0);
        chk("b2b_addr", imem_addr, 32'h210);
        ticks(4);

        // Reset while two words are buffered.
        instr_ready = 0;
        ticks(4);
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1;
        tick();
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_err", {31'd0, addr_err}, 32'd0);
        reset = 0; instr_ready = 1;
        chk("restart_addr", imem_addr, RPC);
        ticks(4);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            instr_ready     = ($urandom_range(0, 3) != 0);
            reset           = ($urandom_range(0, 99) == 0);
            redirect        = ($urandom_range(0, 11) == 0);
            redirect_type   = 2'($urandom_range(0, 3));
            redirect_base   = $urandom & 32'hFFFF_FFFC;
            redirect_imm    = 16'($urandom);
            redirect_target = 26'($urandom);
            redirect_reg    = $urandom;
            if (($urandom_range(0, 7)) == 0) redirect_base = 32'hFFFF_FFF8;
            tick();
        end
        reset = 0; redirect = 0; instr_ready = 1;
        ticks(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
